spislave_st_param: RTL and testbench
====================================

SPISLAVE_ST_PARAM -- requirements
Module: spislave_st_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (legal 4..32).
REQ-002 SHALL have parameter SYNC_DEPTH, default 2, synchronizer stages on sclk/mosi/nss (legal 2..4).
REQ-003 SHALL have parameter CPOL, default 0, sclk idle level.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter LSB_FIRST, default 0: 0 = MSB shifted first.
REQ-006 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of 2, 2..16).
REQ-007 SHALL have parameter IDLE_FILL, default all-ones, word transmitted on TX underrun.
REQ-008 SHALL have port sysclk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-009 SHALL have port nreset  in  1  asynchronous active-low reset.
REQ-010 SHALL have ports sclk, mosi, nss  in  1 each  SPI bus inputs, asynchronous to sysclk; nss is active-low.
REQ-011 SHALL have ports miso  out  1  serial data, and miso_oe  out  1  tri-state enable for the top-level pad.
REQ-012 SHALL have ports stsinkdata  in  DATA_WIDTH, stsinkvalid  in  1, stsinkready  out  1  TX Avalon-ST sink.
REQ-013 SHALL have ports stsourcedata  out  DATA_WIDTH, stsourcevalid  out  1, stsourceready  in  1  RX Avalon-ST source.
REQ-014 SHALL have ports rx_overrun, tx_underrun  out  1 each (sticky), and clr_status  in  1 (clear pulse).

Function
REQ-015 SHALL pass sclk, mosi and nss through SYNC_DEPTH flops; all decisions use the synchronized copies only.
REQ-016 SHALL detect sclk edges from the last two synchronized samples; leading edge = departure from CPOL, trailing edge = return to CPOL.
REQ-017 SHALL sample mosi on the sample edge (per CPHA) and update miso on the opposite edge, only while synchronized nss is low.
REQ-018 SHALL drive miso_oe = NOT synchronized nss; miso = active end of the TX shift register (MSB, or LSB when LSB_FIRST=1).
REQ-019 SHALL, on synchronized nss falling, clear the bit counter and load the TX shift register from the FIFO head (pop) so that for CPHA=0 the first bit is on miso before the first sclk edge.
REQ-020 SHALL, on TX load with FIFO empty, load IDLE_FILL and set tx_underrun; a push in the same cycle is stored, not used.
REQ-021 SHALL count sample edges modulo DATA_WIDTH; on the DATA_WIDTH-th edge the RX word is complete and the next TX word is loaded (per REQ-019/020) for back-to-back words under one nss assertion.
REQ-022 SHALL register a complete RX word to stsourcedata and assert stsourcevalid one sysclk after the completing sample edge is detected.
REQ-023 SHALL hold stsourcedata/stsourcevalid stable until stsourceready is high while stsourcevalid is high; valid then drops next cycle unless a new word completes in that same cycle, in which case the new word is presented.
REQ-024 SHALL, if a word completes while stsourcevalid=1 and stsourceready=0, drop the new word, keep the old one, and set rx_overrun.
REQ-025 SHALL drive stsinkready = FIFO not full; a write occurs when stsinkvalid and stsinkready are both high.
REQ-026 SHALL, on synchronized nss rising mid-word, discard partial RX bits (no output), reset the bit counter, and treat the popped TX word as consumed.
REQ-027 SHALL clear rx_overrun and tx_underrun on clr_status; a set event in the same cycle wins.
REQ-028 SHALL operate correctly provided each sclk half-period is at least SYNC_DEPTH+2 sysclk periods; behaviour is undefined otherwise.

Reset
REQ-029 SHALL, while nreset is low, force miso=0, miso_oe=0, stsourcevalid=0, stsourcedata=0, stsinkready=0, rx_overrun=0, tx_underrun=0, empty the FIFO, and clear the bit counter and synchronizers (nss synchronizer to 1, sclk synchronizer to CPOL).
REQ-030 SHALL raise stsinkready on the first sysclk after reset release; a reset asserted mid-word abandons the word with no output.

Verification
REQ-031 Mode 0, DATA_WIDTH=8: push 0xA5, master sends 0x3C -> miso carries 0xA5 MSB-first, stsourcedata=0x3C, stsourcevalid high one cycle after the 8th rising edge.
REQ-032 Mode 3, DATA_WIDTH=16, LSB_FIRST=1: two back-to-back words 0x1234, 0xBEEF under one nss -> two source beats in order, no gaps lost.
REQ-033 FIFO empty at nss fall -> miso sends 0xFF, tx_underrun=1; clr_status clears it.
REQ-034 stsourceready held low across two words 0x11, 0x22 -> output stays 0x11, rx_overrun=1.
REQ-035 nss deasserted after 5 bits -> no source beat, next frame is received correctly; fill FIFO to TX_DEPTH -> stsinkready=0.
REQ-036 nreset pulsed mid-word -> all outputs at REQ-029 values, next full frame is received correctly.

Source files
------------

// File: rtl/spislave_st_param.sv
`default_nettype none
// ============================================================================
// Module   : spislave_st_param
// Purpose  : SPI slave with Avalon-ST TX sink (through a small FIFO) and
//            Avalon-ST RX source. The SPI bus is oversampled on sysclk
//            through synchronizers. CPOL, CPHA, bit order and word width
//            are all parameters.
// Ports    : sysclk, nreset             - clock, async active-low reset
//            sclk, mosi, nss            - SPI bus inputs (async to sysclk)
//            miso, miso_oe              - serial out and pad tri-state enable
//            stsink{data,valid,ready}   - TX words into the FIFO
//            stsource{data,valid,ready} - received RX words
//            rx_overrun, tx_underrun    - sticky status flags
//            clr_status                 - pulse that clears both flags
// Revision : 1.0 - initial release
// ============================================================================
module spislave_st_param #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SYNC_DEPTH = 2,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter bit                    LSB_FIRST  = 1'b0,
  parameter int                    TX_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '1
) (
  input  logic                  sysclk,
  input  logic                  nreset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  nss,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] stsinkdata,
  input  logic                  stsinkvalid,
  output logic                  stsinkready,
  output logic [DATA_WIDTH-1:0] stsourcedata,
  output logic                  stsourcevalid,
  input  logic                  stsourceready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  input  logic                  clr_status
);

  localparam int                PTR_W    = $clog2(TX_DEPTH);
  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_DEPTH-1:0] sclk_sync;
  logic [SYNC_DEPTH-1:0] mosi_sync;
  logic [SYNC_DEPTH-1:0] nss_sync;
  logic                  sclk_prev;
  logic                  nss_prev;

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      sclk_sync <= {SYNC_DEPTH{CPOL}};
      mosi_sync <= '0;
      nss_sync  <= '1;
      sclk_prev <= CPOL;
      nss_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_DEPTH-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi};
      nss_sync  <= {nss_sync[SYNC_DEPTH-2:0], nss};
      sclk_prev <= sclk_sync[SYNC_DEPTH-1];
      nss_prev  <= nss_sync[SYNC_DEPTH-1];
    end
  end

  logic sclk_s, mosi_s, nss_s;
  logic sclk_lead, sclk_trail;
  logic nss_fall, nss_rise;
  logic sample_edge, shift_edge;
  logic word_done, tx_load;

  assign sclk_s     = sclk_sync[SYNC_DEPTH-1];
  assign mosi_s     = mosi_sync[SYNC_DEPTH-1];
  assign nss_s      = nss_sync[SYNC_DEPTH-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sclk_lead  = (sclk_prev == CPOL) && (sclk_s != CPOL);
  assign sclk_trail = (sclk_prev != CPOL) && (sclk_s == CPOL);
  assign nss_fall   = nss_prev && !nss_s;
  assign nss_rise   = !nss_prev && nss_s;

  assign sample_edge = !nss_s && !nss_fall && (CPHA ? sclk_trail : sclk_lead);
  assign shift_edge  = !nss_s && !nss_fall && (CPHA ? sclk_lead : sclk_trail);

  logic [CNT_W-1:0] bit_cnt;
  assign word_done = sample_edge && (bit_cnt == LAST_BIT);
  assign tx_load   = nss_fall || word_done;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_mem [TX_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full;
  logic                  sink_en;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] tx_head;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign stsinkready = sink_en && !fifo_full;
  assign push        = stsinkvalid && stsinkready;
  // A push landing in the same cycle as a load from an empty FIFO is only
  // stored; the shifter gets IDLE_FILL because the head is not yet valid.
  assign pop         = tx_load && !fifo_empty;
  assign tx_head     = fifo_empty ? IDLE_FILL : fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge sysclk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= stsinkdata;
    end
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sink_en <= 1'b0;
    end else begin
      sink_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // --------------------------------------------------------------------------
  // TX shifter
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_shift_next;
  logic                  skip_shift;

  assign tx_shift_next = LSB_FIRST ? {1'b0, tx_shift[DATA_WIDTH-1:1]}
                                   : {tx_shift[DATA_WIDTH-2:0], 1'b0};

  // After a load the first bit is already on miso. The next shift edge must
  // therefore leave it in place, except for the CPHA=0 frame start where the
  // next edge is a sample edge and the following shift edge must advance.
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      tx_shift   <= '0;
      skip_shift <= 1'b0;
    end else if (tx_load) begin
      tx_shift   <= tx_head;
      skip_shift <= CPHA || word_done;
    end else if (shift_edge) begin
      if (skip_shift) skip_shift <= 1'b0;
      else            tx_shift   <= tx_shift_next;
    end
  end

  assign miso    = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
  assign miso_oe = !nss_s;

  // --------------------------------------------------------------------------
  // RX shifter and bit counter
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;

  assign rx_next = LSB_FIRST ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                             : {rx_shift[DATA_WIDTH-2:0], mosi_s};

  // A partial word left by nss rising is never presented: the counter
  // restarts and the stale rx_shift bits are fully overwritten next word.
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      if (nss_fall || nss_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end
      if (sample_edge) rx_shift <= rx_next;
    end
  end

  // --------------------------------------------------------------------------
  // RX source and sticky status
  // --------------------------------------------------------------------------
  logic overrun_set, underrun_set;

  assign overrun_set  = word_done && stsourcevalid && !stsourceready;
  assign underrun_set = tx_load && fifo_empty;

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      stsourcedata  <= '0;
      stsourcevalid <= 1'b0;
      rx_overrun    <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      if (word_done && !overrun_set) begin
        stsourcedata  <= rx_next;
        stsourcevalid <= 1'b1;
      end else if (stsourcevalid && stsourceready) begin
        stsourcevalid <= 1'b0;
      end

      if (overrun_set)     rx_overrun <= 1'b1;
      else if (clr_status) rx_overrun <= 1'b0;

      if (underrun_set)    tx_underrun <= 1'b1;
      else if (clr_status) tx_underrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spislave_st_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spislave_st_param
// Purpose  : Self-checking bench. Two instances: mode 0 / 8-bit MSB-first
//            and mode 3 / 16-bit LSB-first. A scoreboard queue per instance
//            holds expected RX beats; monitors pop on each source handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spislave_st_param;

  localparam int H = 80;   // sclk half-period in ns (8 sysclk periods)

  logic sysclk = 1'b0;
  logic nreset = 1'b0;
  always #5 sysclk = ~sysclk;

  // Instance 0: CPOL=0 CPHA=0, 8 bit, MSB first
  logic       sclk0 = 1'b0, mosi0 = 1'b0, nss0 = 1'b1;
  logic       miso0, oe0;
  logic [7:0] sinkdata0 = '0;
  logic       sinkvalid0 = 1'b0, sinkready0;
  logic [7:0] srcdata0;
  logic       srcvalid0, srcready0 = 1'b1;
  logic       ovr0, udr0, clr0 = 1'b0;

  // Instance 3: CPOL=1 CPHA=1, 16 bit, LSB first
  logic        sclk3 = 1'b1, mosi3 = 1'b0, nss3 = 1'b1;
  logic        miso3, oe3;
  logic [15:0] sinkdata3 = '0;
  logic        sinkvalid3 = 1'b0, sinkready3;
  logic [15:0] srcdata3;
  logic        srcvalid3, srcready3 = 1'b1;
  logic        ovr3, udr3, clr3 = 1'b0;

  spislave_st_param u_dut0 (
    .sysclk(sysclk), .nreset(nreset), .sclk(sclk0), .mosi(mosi0), .nss(nss0),
    .miso(miso0), .miso_oe(oe0),
    .stsinkdata(sinkdata0), .stsinkvalid(sinkvalid0), .stsinkready(sinkready0),
    .stsourcedata(srcdata0), .stsourcevalid(srcvalid0), .stsourceready(srcready0),
    .rx_overrun(ovr0), .tx_underrun(udr0), .clr_status(clr0)
  );

  spislave_st_param #(
    .DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)
  ) u_dut3 (
    .sysclk(sysclk), .nreset(nreset), .sclk(sclk3), .mosi(mosi3), .nss(nss3),
    .miso(miso3), .miso_oe(oe3),
    .stsinkdata(sinkdata3), .stsinkvalid(sinkvalid3), .stsinkready(sinkready3),
    .stsourcedata(srcdata3), .stsourcevalid(srcvalid3), .stsourceready(srcready3),
    .rx_overrun(ovr3), .tx_underrun(udr3), .clr_status(clr3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  q0 [$];
  logic [15:0] q3 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge sysclk) begin
    if (nreset && srcvalid0 && srcready0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rx0 unexpected beat: got 0x%0h, expected none", srcdata0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        if (srcdata0 !== e) begin
          n_fail++;
          $display("FAIL rx0 beat: got 0x%0h, expected 0x%0h", srcdata0, e);
        end
      end
    end
  end

  always @(negedge sysclk) begin
    if (nreset && srcvalid3 && srcready3) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL rx3 unexpected beat: got 0x%0h, expected none", srcdata3);
      end else begin
        logic [15:0] e;
        e = q3.pop_front();
        if (srcdata3 !== e) begin
          n_fail++;
          $display("FAIL rx3 beat: got 0x%0h, expected 0x%0h", srcdata3, e);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic push0(input logic [7:0] d);
    int n = 0;
    @(negedge sysclk);
    while (!sinkready0 && n < 100) begin @(negedge sysclk); n++; end
    if (!sinkready0) begin
      n_cmp++; n_fail++;
      $display("FAIL push0 timeout: got ready 0, expected 1");
    end else begin
      sinkdata0 = d; sinkvalid0 = 1'b1;
      @(negedge sysclk);
      sinkvalid0 = 1'b0;
    end
  endtask

  task automatic push3(input logic [15:0] d);
    int n = 0;
    @(negedge sysclk);
    while (!sinkready3 && n < 100) begin @(negedge sysclk); n++; end
    if (!sinkready3) begin
      n_cmp++; n_fail++;
      $display("FAIL push3 timeout: got ready 0, expected 1");
    end else begin
      sinkdata3 = d; sinkvalid3 = 1'b1;
      @(negedge sysclk);
      sinkvalid3 = 1'b0;
    end
  endtask

  // Mode 0 master word: drive mosi while sclk low, sample miso before rising.
  task automatic xfer0(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi0 = tx[i];
      #H;
      rx[i] = miso0;
      sclk0 = 1'b1;
      #H;
      sclk0 = 1'b0;
    end
  endtask

  // Mode 3 master word, LSB first: drive on falling, sample before rising.
  task automatic xfer3(input logic [15:0] tx, output logic [15:0] rx);
    for (int i = 0; i < 16; i++) begin
      sclk3 = 1'b0;
      mosi3 = tx[i];
      #H;
      rx[i] = miso3;
      sclk3 = 1'b1;
      #H;
    end
  endtask

  task automatic frame0(input logic [7:0] tx, output logic [7:0] rx);
    nss0 = 1'b0;
    #H;
    xfer0(tx, rx);
    #H;
    nss0 = 1'b1;
    #(2*H);
  endtask

  task automatic clear0();
    @(posedge sysclk); #1 clr0 = 1'b1;
    @(posedge sysclk); #1 clr0 = 1'b0;
  endtask

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0]  r8, r8b;
    logic [15:0] r16;

    // Reset values
    repeat (3) @(posedge sysclk);
    #1;
    check("rst miso",     miso0,      1'b0);
    check("rst miso_oe",  oe0,        1'b0);
    check("rst srcvalid", srcvalid0,  1'b0);
    check("rst srcdata",  srcdata0,   8'h00);
    check("rst sinkrdy",  sinkready0, 1'b0);
    check("rst overrun",  ovr0,       1'b0);
    check("rst underrun", udr0,       1'b0);
    check("rst sinkrdy3", sinkready3, 1'b0);
    @(negedge sysclk);
    nreset = 1'b1;
    @(posedge sysclk);
    #1;
    check("sinkrdy after reset", sinkready0, 1'b1);

    // Mode 3, two back-to-back 16-bit words under one nss
    push3(16'hCAFE);
    push3(16'h5A5A);
    q3.push_back(16'h1234);
    q3.push_back(16'hBEEF);
    nss3 = 1'b0;
    #H;
    xfer3(16'h1234, r16);
    check("m3 miso word1", r16, 16'hCAFE);
    xfer3(16'hBEEF, r16);
    check("m3 miso word2", r16, 16'h5A5A);
    #H;
    nss3 = 1'b1;
    #(2*H);

    // Mode 0 basic word
    push0(8'hA5);
    q0.push_back(8'h3C);
    frame0(8'h3C, r8);
    check("m0 miso A5", r8, 8'hA5);
    clear0();

    // Underrun: FIFO empty at nss fall
    check("udr cleared", udr0, 1'b0);
    q0.push_back(8'h5A);
    frame0(8'h5A, r8);
    check("udr miso fill", r8, 8'hFF);
    check("udr set", udr0, 1'b1);
    clear0();
    check("udr clr", udr0, 1'b0);

    // Overrun: source stalled across two words
    @(posedge sysclk); #1 srcready0 = 1'b0;
    q0.push_back(8'h11);
    nss0 = 1'b0;
    #H;
    xfer0(8'h11, r8);
    xfer0(8'h22, r8);
    #H;
    nss0 = 1'b1;
    #(2*H);
    check("ovr set",      ovr0,      1'b1);
    check("ovr srcdata",  srcdata0,  8'h11);
    check("ovr srcvalid", srcvalid0, 1'b1);
    @(posedge sysclk); #1 srcready0 = 1'b1;
    repeat (4) @(posedge sysclk);
    clear0();
    check("ovr clr", ovr0, 1'b0);

    // Partial word aborted after 5 bits
    nss0 = 1'b0;
    #H;
    for (int i = 0; i < 5; i++) begin
      mosi0 = 1'b1;
      #H; sclk0 = 1'b1;
      #H; sclk0 = 1'b0;
    end
    #H;
    nss0 = 1'b1;
    #(4*H);
    check("partial no beat", srcvalid0, 1'b0);
    q0.push_back(8'hC3);
    frame0(8'hC3, r8);

    // Fill FIFO to depth, then drain two words in one frame
    push0(8'h01);
    push0(8'h02);
    push0(8'h03);
    push0(8'h04);
    check("fifo full sinkrdy", sinkready0, 1'b0);
    q0.push_back(8'h96);
    q0.push_back(8'h69);
    nss0 = 1'b0;
    #H;
    xfer0(8'h96, r8);
    xfer0(8'h69, r8b);
    #H;
    nss0 = 1'b1;
    #(2*H);
    check("fifo miso w1", r8,  8'h01);
    check("fifo miso w2", r8b, 8'h02);

    // Reset asserted mid-word
    nss0 = 1'b0;
    #H;
    for (int i = 0; i < 3; i++) begin
      mosi0 = 1'b0;
      #H; sclk0 = 1'b1;
      #H; sclk0 = 1'b0;
    end
    nreset = 1'b0;
    nss0   = 1'b1;
    #20;
    check("mid rst miso",     miso0,      1'b0);
    check("mid rst miso_oe",  oe0,        1'b0);
    check("mid rst srcvalid", srcvalid0,  1'b0);
    check("mid rst srcdata",  srcdata0,   8'h00);
    check("mid rst sinkrdy",  sinkready0, 1'b0);
    check("mid rst overrun",  ovr0,       1'b0);
    check("mid rst underrun", udr0,       1'b0);
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    nreset = 1'b1;
    push0(8'h4B);
    q0.push_back(8'hE1);
    frame0(8'hE1, r8);
    check("post rst miso", r8, 8'h4B);

    repeat (10) @(posedge sysclk);
    check("rx0 queue drained", q0.size(), 0);
    check("rx3 queue drained", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
